reg_bank_wr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the write port of a bank of NREG enabled D flip-flop registers
//  (BITS wide each) between NREQ requesters. It picks one requester per cycle, latches its data,
//  and drives one-hot write enables to the register bank. The bank is NREG flip-flops, each

---
 rtl/reg_bank_wr_arbiter.sv | 110 +++++++++++
 tb/tb_reg_bank_wr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin arbiter sharing one register-bank write port between NREQ requesters.
// One grant per cycle; all outputs are registered and cleared by the async active-low reset.
module reg_bank_wr_arbiter #(
  parameter int BITS = 8,
  parameter int NREQ = 4,
  parameter int NREG = 4,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*BITS-1:0] req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREG-1:0]      wr_enb,
  output logic [BITS-1:0]      wr_data,
  output logic                 addr_err,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREG-1:0] wr_enb_q, wr_enb_d;
  logic [BITS-1:0] wr_data_q, wr_data_d;
  logic            addr_err_q, addr_err_d;

  logic [NREQ-1:0] eligible;
  logic            selValid;
  logic [PW-1:0]   selIdx;
  logic [PW-1:0]   scanIdx;
  logic [AW-1:0]   selAddr;
  int              scanSum;

  // The requester granted last cycle is masked so a slow req drop cannot win twice.
  always_comb begin
    eligible = req & ~gnt_q;
    selValid = 1'b0;
    selIdx   = '0;
    scanSum  = 0;
    scanIdx  = '0;
    for (int off = 0; off < NREQ; off++) begin
      scanSum = int'(ptr_q) + off;
      if (scanSum >= NREQ) scanSum = scanSum - NREQ;
      scanIdx = PW'(scanSum);
      if (!selValid && eligible[scanIdx]) begin
        selValid = 1'b1;
        selIdx   = scanIdx;
      end
    end
    selAddr = req_addr[selIdx*AW +: AW];
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      wr_enb_q   <= '0;
      wr_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      wr_enb_q   <= wr_enb_d;
      wr_data_q  <= wr_data_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d = selValid ? GRANT : IDLE;
    ptr_d   = ptr_q;
    if (selValid) begin
      ptr_d = (selIdx == PW'(NREQ - 1)) ? '0 : selIdx + PW'(1);
    end
  end

  // Out-of-range addresses still consume the grant but never reach the bank.
  always_comb begin
    gnt_d      = '0;
    wr_enb_d   = '0;
    wr_data_d  = '0;
    addr_err_d = 1'b0;
    if (selValid) begin
      gnt_d[selIdx] = 1'b1;
      if (int'(selAddr) < NREG) begin
        wr_enb_d  = NREG'(1) << selAddr;
        wr_data_d = req_data[selIdx*BITS +: BITS];
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

  assign gnt      = gnt_q;
  assign wr_enb   = wr_enb_q;
  assign wr_data  = wr_data_q;
  assign addr_err = addr_err_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Scoreboard bench for reg_bank_wr_arbiter: a round-robin reference model predicts each grant,
// a negedge monitor pops predictions whenever the DUT grants, and a bank model checks data.
module tb_reg_bank_wr_arbiter;

  localparam int BITS = 8;
  localparam int NREQ = 4;
  localparam int NREG = 4;
  localparam int AW   = 4;

  logic                 clk;
  logic                 reset_L;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*BITS-1:0] req_data;
  logic [NREQ-1:0]      gnt;
  logic [NREG-1:0]      wr_enb;
  logic [BITS-1:0]      wr_data;
  logic                 addr_err;
  logic                 busy;

  reg_bank_wr_arbiter #(.BITS(BITS), .NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .wr_enb   (wr_enb),
    .wr_data  (wr_data),
    .addr_err (addr_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [NREG-1:0] wrEnb;
    logic [BITS-1:0] wrData;
    logic            addrErr;
  } exp_t;

  exp_t            sbQueue[$];
  exp_t            popped;
  int              assertCount = 0;
  int              failCount   = 0;
  int              mPtr        = 0;
  int              mPrev       = -1;
  int              lastGrant   = -1;
  logic [BITS-1:0] bankExp[NREG];
  logic [BITS-1:0] bankAct[NREG];
  bit              pendR[NREQ];
  logic [AW-1:0]   pendA[NREQ];
  logic [BITS-1:0] pendD[NREQ];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mPtr      = 0;
    mPrev     = -1;
    lastGrant = -1;
    for (int i = 0; i < NREQ; i++) pendR[i] = 1'b0;
  endtask

  // Drive one cycle of requests and predict what the coming edge must grant.
  task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                               input logic [NREQ*BITS-1:0] d);
    exp_t e;
    int   k;
    int   av;
    @(negedge clk);
    req      = r;
    req_addr = a;
    req_data = d;
    k = -1;
    for (int off = 0; off < NREQ; off++) begin
      int i;
      i = (mPtr + off) % NREQ;
      if (k < 0 && r[i] && i != mPrev) k = i;
    end
    if (k >= 0) begin
      e.gnt     = '0;
      e.gnt[k]  = 1'b1;
      e.wrEnb   = '0;
      e.wrData  = '0;
      e.addrErr = 1'b0;
      av = int'(a[k*AW +: AW]);
      if (av < NREG) begin
        e.wrEnb[av] = 1'b1;
        e.wrData    = d[k*BITS +: BITS];
      end else begin
        e.addrErr = 1'b1;
      end
      sbQueue.push_back(e);
      mPtr  = (k + 1) % NREQ;
      mPrev = k;
    end else begin
      mPrev = -1;
    end
    lastGrant = k;
  endtask

  task automatic idleCycles(input int n);
    for (int c = 0; c < n; c++) applyStimulus('0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (reset_L) begin
      checkOutput("inv_onehot_gnt", 32'($onehot0(gnt)), 32'd1);
      checkOutput("inv_onehot_wr_enb", 32'($onehot0(wr_enb)), 32'd1);
      checkOutput("inv_wr_implies_gnt", 32'((wr_enb == '0) || (gnt != '0)), 32'd1);
      checkOutput("inv_busy", 32'(busy), 32'(gnt != '0));
      for (int i = 0; i < NREG; i++) if (wr_enb[i]) bankAct[i] = wr_data;
      if (gnt != '0) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_grant", 32'(gnt), 32'd0);
        end else begin
          popped = sbQueue.pop_front();
          checkOutput("gnt", 32'(gnt), 32'(popped.gnt));
          checkOutput("wr_enb", 32'(wr_enb), 32'(popped.wrEnb));
          checkOutput("wr_data", 32'(wr_data), 32'(popped.wrData));
          checkOutput("addr_err", 32'(addr_err), 32'(popped.addrErr));
          for (int i = 0; i < NREG; i++) if (popped.wrEnb[i]) bankExp[i] = popped.wrData;
        end
      end
    end
  end

  initial begin
    logic [NREQ-1:0]      r;
    logic [NREQ*AW-1:0]   a;
    logic [NREQ*BITS-1:0] d;

    for (int i = 0; i < NREG; i++) begin
      bankExp[i] = '0;
      bankAct[i] = '0;
    end
    resetModel();
    reset_L  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    #12;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_wr_enb", 32'(wr_enb), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_L = 1'b1;

    // Asynchronous reset while a grant is on the outputs, then restart from requester 0.
    applyStimulus(4'b1111, {4'd0, 4'd1, 4'd2, 4'd3}, {8'h44, 8'h33, 8'h22, 8'h11});
    applyStimulus(4'b1111, {4'd0, 4'd1, 4'd2, 4'd3}, {8'h44, 8'h33, 8'h22, 8'h11});
    @(posedge clk);
    #1 reset_L = 1'b0;
    #1;
    checkOutput("async_rst_gnt", 32'(gnt), 32'd0);
    checkOutput("async_rst_wr_enb", 32'(wr_enb), 32'd0);
    checkOutput("async_rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("async_rst_addr_err", 32'(addr_err), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    sbQueue.delete();
    resetModel();
    #2 reset_L = 1'b1;
    applyStimulus(4'b1111, {4'd0, 4'd1, 4'd2, 4'd3}, {8'h44, 8'h33, 8'h22, 8'h11});
    idleCycles(2);

    applyStimulus(4'b0100, {4'd0, 4'd3, 4'd0, 4'd0}, {8'h00, 8'hA5, 8'h00, 8'h00});
    idleCycles(2);

    for (int c = 0; c < 8; c++)
      applyStimulus(4'b1111, {4'd3, 4'd2, 4'd1, 4'd0}, {8'hD4, 8'hC3, 8'hB2, 8'hA1});
    idleCycles(2);

    applyStimulus(4'b0100, {4'd0, 4'd1, 4'd0, 4'd0}, {8'h00, 8'h5A, 8'h00, 8'h00});
    idleCycles(1);
    applyStimulus(4'b0011, {4'd0, 4'd0, 4'd2, 4'd3}, {8'h00, 8'h00, 8'h77, 8'h66});
    applyStimulus(4'b0011, {4'd0, 4'd0, 4'd2, 4'd3}, {8'h00, 8'h00, 8'h77, 8'h66});
    idleCycles(2);

    applyStimulus(4'b0001, {4'd0, 4'd0, 4'd0, 4'd5}, {8'h00, 8'h00, 8'h00, 8'hEE});
    applyStimulus(4'b0010, {4'd0, 4'd0, 4'd1, 4'd0}, {8'h00, 8'h00, 8'h3C, 8'h00});
    idleCycles(2);

    // Random requesters obey the handshake: hold until granted, may withdraw early.
    for (int c = 0; c < 100; c++) begin
      r = '0;
      a = '0;
      d = '0;
      for (int i = 0; i < NREQ; i++) begin
        r[i] = pendR[i];
        a[i*AW +: AW] = pendA[i];
        d[i*BITS +: BITS] = pendD[i];
      end
      applyStimulus(r, a, d);
      if (lastGrant >= 0) pendR[lastGrant] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (pendR[i]) begin
          if ($urandom_range(0, 9) == 0) pendR[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          pendR[i] = 1'b1;
          pendA[i] = AW'($urandom_range(0, 5));
          pendD[i] = BITS'($urandom);
        end
      end
    end
    idleCycles(3);

    checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
    for (int i = 0; i < NREG; i++)
      checkOutput($sformatf("bank_reg%0d", i), 32'(bankAct[i]), 32'(bankExp[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
